pipeline_imem_resp: RTL and testbench

//  Instruction-fetch responder: the memory end of the fetch interface driven by pipeline_if.

---
 rtl/pipeline_imem_resp.sv | 126 ++++++++++++
 tb/tb_pipeline_imem_resp.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_imem_resp.sv
// Instruction-fetch responder: serves the IF-stage PC from a single buffered line and
// refills that line word-by-word over a req/ack memory bus on a miss.
module pipeline_imem_resp #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        misalign,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int OFF       = WORD_BITS + 2;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  state_t               state, state_next;
  logic                 line_valid;
  logic [31:OFF]        line_tag;
  logic [WORD_BITS-1:0] counter;
  logic [31:0]          line_buf [LINE_WORDS];

  logic [31:OFF]        tag;
  logic [WORD_BITS-1:0] word;
  logic                 hit;
  logic                 last_word;
  logic                 start_fill;
  logic                 accept;

  assign tag        = pc[31:OFF];
  assign word       = pc[OFF-1:2];
  assign misalign   = (pc[1:0] != 2'b00);
  assign hit        = line_valid && (tag == line_tag) && !misalign;
  assign last_word  = (counter == WORD_BITS'(LINE_WORDS - 1));
  assign start_fill = (state == IDLE) && !hit && !misalign && !flush;
  // A word is kept only if the fill is still live; a flush on the ack cycle discards it.
  assign accept     = (state == FILL) && mem_ack && !flush;
  assign mem_req    = (state != IDLE);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    instr       = 32'h0;
    instr_valid = 1'b0;
    stall       = 1'b0;
    if (reset) begin
      if (state != IDLE) begin
        stall = 1'b1;
      end else if (hit) begin
        instr       = line_buf[word];
        instr_valid = 1'b1;
      end else if (!misalign) begin
        stall = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_fill) state_next = FILL;
      end
      FILL: begin
        if (mem_ack) begin
          if (flush || last_word) state_next = IDLE;
        end else if (flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      line_valid <= 1'b0;
      line_tag   <= '0;
      counter    <= '0;
      mem_addr   <= 32'h0;
    end else if (start_fill) begin
      line_valid <= 1'b0;
      line_tag   <= tag;
      counter    <= '0;
      mem_addr   <= {tag, {OFF{1'b0}}};
    end else if (accept) begin
      if (last_word) begin
        line_valid <= 1'b1;
      end else begin
        counter  <= counter + 1'b1;
        mem_addr <= mem_addr + 32'd4;
      end
    end
  end

  // NOTE: the line storage has no reset; line_valid alone guards its contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[counter] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_pipeline_imem_resp.sv
// Self-checking bench for pipeline_imem_resp: directed fetch scenarios plus random traffic,
// compared every cycle against a transaction-level model of the single-line buffer.
module tb_pipeline_imem_resp;

  localparam int LW  = 4;
  localparam int OFF = $clog2(LW) + 2;

  logic        clk = 1'b0;
  logic        reset, flush, mem_ack;
  logic [31:0] pc, mem_rdata;
  logic [31:0] instr, mem_addr;
  logic        instr_valid, stall, misalign, mem_req;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_imem_resp #(.LINE_WORDS(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .misalign    (misalign),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  // Reference model: cached line (base, valid, words) and an outstanding-fill descriptor.
  bit          m_valid = 0;
  bit          m_busy  = 0;
  bit          m_drain = 0;
  logic [31:0] m_base  = 32'h0;
  int          m_idx   = 0;
  logic [31:0] m_buf [LW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a3c_96e1;
  endfunction

  function automatic logic [31:0] m_addr();
    return m_base + 32'(4 * m_idx);
  endfunction

  task automatic drive(input logic [31:0] p, input logic f, input logic a, input logic r = 1'b1);
    pc        = p;
    flush     = f;
    mem_ack   = a;
    reset     = r;
    mem_rdata = a ? mem_fn(m_addr()) : $urandom;
  endtask

  // Compare all outputs mid-cycle, then advance the model with the inputs the DUT samples.
  task automatic step();
    logic [31:0] e_instr;
    logic        e_valid, e_stall;
    bit          mis, hit;
    @(negedge clk);
    mis     = (pc[1:0] != 2'b00);
    hit     = m_valid && !m_busy && !mis && (pc[31:OFF] == m_base[31:OFF]);
    e_instr = 32'h0;
    e_valid = 1'b0;
    e_stall = 1'b0;
    if (reset) begin
      if (m_busy) e_stall = 1'b1;
      else if (hit) begin
        e_valid = 1'b1;
        e_instr = m_buf[pc[OFF-1:2]];
      end else if (!mis) e_stall = 1'b1;
    end
    check("misalign", misalign, mis);
    check("instr_valid", instr_valid, e_valid);
    check("stall", stall, e_stall);
    check("instr", instr, e_instr);
    check("mem_req", mem_req, m_busy);
    if (m_busy) check("mem_addr", mem_addr, m_addr());

    if (!reset) begin
      m_valid = 0;
      m_busy  = 0;
      m_drain = 0;
      m_idx   = 0;
    end else if (!m_busy) begin
      if (!hit && !mis && !flush) begin
        m_busy  = 1;
        m_drain = 0;
        m_valid = 0;
        m_base  = {pc[31:OFF], {OFF{1'b0}}};
        m_idx   = 0;
      end
    end else if (m_drain) begin
      if (mem_ack) m_busy = 0;
    end else if (flush) begin
      if (mem_ack) m_busy = 0;
      else m_drain = 1;
    end else if (mem_ack) begin
      m_buf[m_idx] = mem_fn(m_addr());
      if (m_idx == LW - 1) begin
        m_busy  = 0;
        m_valid = 1;
      end else begin
        m_idx++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Present pc, then answer each request after 'waits' idle cycles until the fill ends.
  task automatic fill_with_wait(input logic [31:0] p, input int waits);
    int budget = 200;
    int w = 0;
    drive(p, 1'b0, 1'b0);
    step();
    while (m_busy && budget > 0) begin
      if (w >= waits) begin
        drive(p, 1'b0, 1'b1);
        w = 0;
      end else begin
        drive(p, 1'b0, 1'b0);
        w++;
      end
      step();
      budget--;
    end
    check("fill_end_req", mem_req, 32'h0);
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] bases [4];
    logic [31:0] p;
    bases[0] = 32'h0000_0100;
    bases[1] = 32'h0000_0110;
    bases[2] = 32'h0000_0200;
    bases[3] = 32'hffff_fff0;
    p = bases[$urandom_range(0, 3)] + 32'(4 * $urandom_range(0, LW - 1));
    if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
    return p;
  endfunction

  initial begin
    logic [31:0] rp;

    // Cold miss then hits
    drive(32'h100, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("rst_mem_addr", mem_addr, 32'h0);
    fill_with_wait(32'h100, 1);
    drive(32'h100, 1'b0, 1'b0);
    step();
    check("t1_word0", instr, mem_fn(32'h100));
    for (int i = 1; i < LW; i++) begin
      drive(32'h100 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    check("t1_word3", instr, mem_fn(32'h10c));

    // Line change, then the old line misses again
    fill_with_wait(32'h110, 0);
    fill_with_wait(32'h100, 2);

    // Flush while the second request waits
    drive(32'h200, 1'b0, 1'b0); step();
    drive(32'h200, 1'b0, 1'b1); step();
    drive(32'h200, 1'b0, 1'b0); step();
    drive(32'h200, 1'b1, 1'b0); step();
    drive(32'h240, 1'b0, 1'b0); step();
    step();
    check("t3_drain_addr", mem_addr, 32'h204);
    check("t3_drain_req", mem_req, 32'h1);
    drive(32'h240, 1'b0, 1'b1); step();
    check("t3_end_req", mem_req, 32'h0);
    fill_with_wait(32'h200, 1);

    // Flush coincident with the ack of word 2
    drive(32'h400, 1'b0, 1'b0); step();
    drive(32'h400, 1'b0, 1'b1); step();
    drive(32'h400, 1'b0, 1'b1); step();
    drive(32'h400, 1'b0, 1'b0); step();
    drive(32'h400, 1'b1, 1'b1); step();
    check("t4_req", mem_req, 32'h0);
    fill_with_wait(32'h400, 0);

    // Misaligned pc
    drive(32'h102, 1'b0, 1'b0); step();
    check("t5_req", mem_req, 32'h0);
    check("t5_stall", stall, 32'h0);

    // Reset mid-fill, then refill
    drive(32'h300, 1'b0, 1'b0); step();
    drive(32'h300, 1'b0, 1'b1); step();
    drive(32'h300, 1'b0, 1'b0, 1'b0); step();
    check("t6_req", mem_req, 32'h0);
    fill_with_wait(32'h300, 1);

    // Top-of-memory line
    fill_with_wait(32'hffff_fff0, 0);
    drive(32'hffff_fffc, 1'b0, 1'b0); step();
    check("wrap_instr", instr, mem_fn(32'hffff_fffc));

    // Random traffic
    rp = 32'h100;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rp = pick_pc();
      drive(rp, ($urandom_range(0, 9) == 0), (m_busy && $urandom_range(0, 2) != 0),
            ($urandom_range(0, 49) != 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
